// File: rtl/uart_pkg.sv
// Shared types and constants for the AXI-Stream UART transmitter.
// The serializer state enum keeps PARITY even when the parity build option is off.
package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit, truncating.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with push/pop/full/empty/level.
// Pointers and level reset asynchronously; the storage array is never reset.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_axis_tx.sv
// AXI-Stream byte slave feeding an 8N1 UART serializer through a small FIFO.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frame).
module uart_axis_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV         = uart_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned STOP_CYCLES = DIV * UART_STOP_BITS;
  localparam int          CW          = $clog2(STOP_CYCLES);
  localparam int          IW          = $clog2(UART_DATA_W);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_W - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_axis_tx: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
  end

  uart_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   pop, push, bit_end, stop_end;
  logic                   fifo_full, fifo_empty;
  logic [UART_DATA_W-1:0] fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Handshake: a byte transfers on a rising edge when tvalid && tready;
  // tready depends only on registered FIFO state, never on tvalid.
  assign s_axis_tready = !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign uart_txd      = txd_q;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (s_axis_tdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    bit_end  = (cnt_q == BIT_LAST);
    stop_end = (cnt_q == STOP_LAST);
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more bytes wait.
        if (stop_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = ST_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the next state so the line changes on the entry edge.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_axis_tx.sv
// Bench for uart_axis_tx: waveform-queue reference model compared every cycle,
// plus literal frame, latency, back-pressure and reset expectations.
module tb_uart_axis_tx;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
  localparam logic [FL-1:0] LIT55 = 11'b10010101010;
`else
  localparam int FL = 10;
  localparam logic [FL-1:0] LIT55 = 10'b1010101010;
`endif
  localparam int FLC = FL * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       uart_txd;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int failures = 0;

  logic       wave[$];
  logic [7:0] fifo_m[$];
  logic       m_push;
  logic [7:0] m_byte;
  logic       m_drop;
  logic       samp[0:1023];

  uart_axis_tx #(
    .CLK_FREQ_HZ (100),
    .BAUD_RATE   (10),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .uart_txd      (uart_txd),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle expected txd values queued when a byte is popped.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave.delete();
      fifo_m.delete();
    end else begin
      m_push = s_axis_tvalid && (fifo_m.size() < DEPTH);
      if (wave.size() > 0) m_drop = wave.pop_front();
      if (wave.size() == 0 && fifo_m.size() > 0) begin
        m_byte = fifo_m.pop_front();
        for (int c = 0; c < DIV; c++) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int c = 0; c < DIV; c++) wave.push_back(m_byte[i]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < DIV; c++) wave.push_back(^m_byte);
`endif
        for (int c = 0; c < DIV; c++) wave.push_back(1'b1);
      end
      if (m_push) fifo_m.push_back(s_axis_tdata);
    end
  end

  always @(negedge clk) begin
    logic e_txd;
    e_txd = (wave.size() > 0) ? wave[0] : 1'b1;
    chk("txd", 32'(uart_txd), 32'(e_txd));
    chk("busy", 32'(busy), 32'((wave.size() > 0) || (fifo_m.size() > 0)));
    chk("level", 32'(fifo_level), 32'(fifo_m.size()));
    chk("tready", 32'(s_axis_tready), 32'(fifo_m.size() < DEPTH));
  end

  // Called just after a falling edge; returns just after the falling edge
  // following the acceptance edge.
  task automatic send(input logic [7:0] b);
    int  waited;
    bit  rdy;
    bit  accepted;
    waited = 0;
    accepted = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    while (!accepted && waited <= 400) begin
      rdy = s_axis_tready;
      @(posedge clk);
      @(negedge clk);
      #1;
      if (rdy) accepted = 1;
      else waited++;
    end
    if (!accepted) chk("send_tready_timeout", 32'(s_axis_tready), 32'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      s_axis_tdata = 8'($urandom_range(0, 255));
      @(negedge clk);
      #1;
    end
  endtask

  task automatic record(input int k0, output int k_end);
    int k;
    k = k0;
    while (busy === 1'b1 && k < 1000) begin
      samp[k] = uart_txd;
      k++;
      @(negedge clk);
      #1;
    end
    k_end = k;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int k_end;
    logic [FL-1:0] got;
    logic [7:0] d1, d2;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    idle_cycles(50);
    chk("idle_txd", 32'(uart_txd), 32'd1);

    // Single 0x55 frame
    send(8'h55);
    record(0, k_end);
    chk("frame55_busy_len", 32'(k_end), 32'(FLC + 1));
    for (int j = 0; j < FL; j++) got[j] = samp[5 + DIV * j];
    chk("frame55_bits", 32'(got), 32'(LIT55));
    chk("frame55_first_low", 32'(samp[1]), 32'd0);
    chk("frame55_level", 32'(fifo_level), 32'd0);

    // Back-to-back 0xA5, 0x3C: no gap, order preserved
    send(8'hA5);
    send(8'h3C);
    record(1, k_end);
    chk("b2b_busy_len", 32'(k_end), 32'(2 * FLC + 1));
    for (int i = 0; i < 8; i++) begin
      d1[i] = samp[5 + DIV * (1 + i)];
      d2[i] = samp[FLC + 5 + DIV * (1 + i)];
    end
    chk("b2b_byte0", 32'(d1), 32'h A5);
    chk("b2b_byte1", 32'(d2), 32'h 3C);
    chk("b2b_stop_last", 32'(samp[FLC]), 32'd1);
    chk("b2b_stop_first", 32'(samp[FLC - DIV + 1]), 32'd1);
    chk("b2b_next_start", 32'(samp[FLC + 1]), 32'd0);
    wait_idle(100);

    // Six bytes with tvalid held: FIFO fills, back-pressure, drains in order
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    chk("burst_level_full", 32'(fifo_level), 32'd4);
    chk("burst_tready_low", 32'(s_axis_tready), 32'd0);
    send(8'h66);
    wait_idle(1000);
    idle_cycles(5);

    // Reset during a 0x0F frame at cycle 35 (line high) and cycle 65 (line low)
    send(8'h0F);
    repeat (35) @(negedge clk);
    #1;
    chk("rst35_pre_txd", 32'(uart_txd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst35_txd", 32'(uart_txd), 32'd1);
    chk("rst35_level", 32'(fifo_level), 32'd0);
    chk("rst35_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(30);
    chk("rst35_after_txd", 32'(uart_txd), 32'd1);

    send(8'h0F);
    send(8'h77);
    repeat (64) @(negedge clk);
    #1;
    chk("rst65_pre_txd", 32'(uart_txd), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst65_txd", 32'(uart_txd), 32'd1);
    chk("rst65_level", 32'(fifo_level), 32'd0);
    chk("rst65_tready", 32'(s_axis_tready), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(150);
    chk("rst65_after_txd", 32'(uart_txd), 32'd1);
    chk("rst65_after_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    record(0, k_end);
    chk("par07_len", 32'(k_end), 32'd111);
    chk("par07_bit", 32'(samp[95]), 32'd1);
    send(8'h03);
    record(0, k_end);
    chk("par03_bit", 32'(samp[95]), 32'd0);
    idle_cycles(3);
`endif

    // Randomized traffic with idle gaps and occasional bursts
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 5; j++) send(8'($urandom_range(0, 255)));
      end else begin
        idle_cycles($urandom_range(1, 120));
        send(8'($urandom_range(0, 255)));
      end
    end
    wait_idle(5000);
    idle_cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_axis_tx.md
Name: uart_axis_tx

Overview:
- Byte-wide AXI-Stream slave to serial 8N1 UART transmitter.
- Sits directly downstream of the MMIO block's UART byte stream (tdata[7:0]/tvalid/tready) and drives the chip's TX pin.
- Absorbs bursts of CPU console writes in a small FIFO, then serializes each byte LSB-first at a fixed baud rate.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate. DIV = CLK_FREQ_HZ/BAUD_RATE (integer, truncating), must be >= 2; elaboration error otherwise.
- FIFO_DEPTH, 16, byte entries; power of 2, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  8  byte to transmit.
- s_axis_tvalid  in  1  tdata valid.
- s_axis_tready  out  1  FIFO can accept a byte.
- uart_txd  out  1  serial output, idle high.
- busy  out  1  serializer not IDLE, or FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low. All flops clear on rst_n low.
- Reset values: uart_txd=1, busy=0, fifo_level=0, s_axis_tready=1, serializer state IDLE, baud counter 0.
- s_axis_tready = (fifo_level != FIFO_DEPTH), registered-state-derived with no combinational path from tvalid.
- Push occurs on a rising edge with tvalid && tready.
- When full, tready=0 even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: level unchanged, data order preserved.
- Serializer states:
  - IDLE: txd=1. If level>0, pop the head into shift register and go to START.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles per bit, shifting right. After bit 7 go to PARITY if enabled, else STOP.
  - PARITY (optional): txd=parity bit for DIV cycles, then STOP.
  - STOP: txd=1 for DIV cycles. On the last stop cycle, if level>0, pop and go to START (no idle gap); else go to IDLE.
- Baud counter: counts 0..DIV-1, resets on every state entry. A bit ends when the counter reaches DIV-1. Every bit lasts exactly DIV cycles.
- uart_txd is a registered output (glitch-free).
- Latency: handshake on edge N into an empty, idle block gives pop at edge N+1, and txd falls after edge N+1.
- Frame length: 10*DIV cycles (11*DIV with parity).
- Reset mid-frame: txd returns to 1 asynchronously, FIFO contents are discarded, and no partial frame resumes.
- tdata is ignored when tvalid=0. FIFO storage does not need reset, but the pointers do.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds the PARITY state carrying even parity (XOR of the 8 data bits), giving an 8E1 frame of 11 bit-times.
- Undefined: no PARITY state and no parity logic; 8N1 frame of 10 bit-times.
- Port list is identical in both cases.

Decomposition:
- Package uart_pkg holds:
  - Serializer state enum (IDLE, START, DATA, PARITY, STOP).
  - Data width constant UART_DATA_W=8.
  - Stop-bit count constant UART_STOP_BITS=1.
  - Function computing DIV from CLK_FREQ_HZ and BAUD_RATE.
- One sub-module, uart_tx_fifo: synchronous single-clock FIFO with push/pop/full/empty/level, async active-low reset on pointers.
- The serializer FSM and baud counter live in uart_axis_tx.

Test Plan (CLK_FREQ_HZ=100, BAUD_RATE=10, so DIV=10; FIFO_DEPTH=4):
- Reset check: hold rst_n=0 → txd=1, tready=1, busy=0, level=0. Release; no stimulus for 50 cycles → txd stays 1.
- Single 0x55 → txd after pop: 0,1,0,1,0,1,0,1,0,1 each 10 cycles, then stop=1 (100 cycles total); busy falls after the frame; level returns to 0.
- Push 0xA5,0x3C back-to-back → two frames with no gap: stop bit of the first is exactly 10 cycles, then the start bit of the second follows immediately; data order is preserved.
- Push 6 bytes with tvalid held high → first byte popped immediately; 4 buffered; tready=0 with level=4 until the next pop; all 6 bytes appear in order on txd.
- Reset mid-frame: assert rst_n=0 at cycle 35 of a 0x0F frame → txd=1 immediately (asynchronous); after release no residual bits and level=0.
- UART_TX_PARITY_EN defined: send 0x07 → parity bit 1; send 0x03 → parity bit 0; frame length 110 cycles.
